// File: rtl/tx_word_sequencer.sv
// tx_word_sequencer: frames one 16-bit word per transfer onto a serial line.
// The word is latched onto the external 16:1 mux inputs. The mux select is
// stepped LSB first, and the mux output is framed with a start bit and a stop bit.
module tx_word_sequencer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        abort,
  output logic [15:0] word_q,
  output logic [3:0]  sel,
  input  logic        mux_in,
  output logic        tx_out,
  output logic        busy,
  output logic        done
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned BCNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(CLKS_PER_BIT - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BCNT_W-1:0]   r_bcnt;
  logic [BCNT_W-1:0]   w_bcnt_nxt;
  logic [SEL_W-1:0]    r_sel;
  logic [SEL_W-1:0]    w_sel_nxt;
  logic [WORD_W-1:0]   r_word;
  logic [WORD_W-1:0]   w_word_nxt;
  logic                r_done;
  logic                w_done_nxt;
  logic                w_handshake;
  logic                w_bit_end;

  assign w_handshake = in_valid && (r_state == S_IDLE);
  assign w_bit_end   = (r_bcnt == BCNT_MAX);

  // State, counters, latched word and completion pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
      r_sel   <= '0;
      r_word  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_sel   <= w_sel_nxt;
      r_word  <= w_word_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic; abort in any busy state wins over bit-period progress.
  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    w_sel_nxt   = r_sel;
    w_word_nxt  = r_word;
    w_done_nxt  = 1'b0;

    if ((r_state != S_IDLE) && abort) begin
      w_state_nxt = S_IDLE;
      w_bcnt_nxt  = '0;
      w_sel_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_handshake) begin
            w_word_nxt  = in_data;
            w_sel_nxt   = '0;
            w_bcnt_nxt  = '0;
            w_state_nxt = S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            w_bcnt_nxt  = '0;
            w_state_nxt = S_DATA;
          end else begin
            w_bcnt_nxt = r_bcnt + BCNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            w_bcnt_nxt = '0;
            if (r_sel == SEL_LAST) begin
              w_state_nxt = S_STOP;
            end else begin
              w_sel_nxt = r_sel + SEL_W'(1);
            end
          end else begin
            w_bcnt_nxt = r_bcnt + BCNT_W'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            w_bcnt_nxt  = '0;
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_bcnt_nxt = r_bcnt + BCNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Serial line: idle/stop high, start low, data straight from the mux.
  always_comb begin
    tx_out = 1'b1;
    case (r_state)
      S_START: tx_out = 1'b0;
      S_DATA:  tx_out = mux_in;
      default: tx_out = 1'b1;
    endcase
  end

  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign word_q   = r_word;
  assign sel      = r_sel;

endmodule

// File: tb/tb_tx_word_sequencer.sv
// Testbench for tx_word_sequencer: frame table, corner sequences, random vs model.
module tb_tx_word_sequencer;

  localparam int C     = 4;
  localparam int FRAME = 18 * C;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [15:0] a_data, a_wq;
  logic        a_valid, a_abort, a_ready, a_mux, a_tx, a_busy, a_done;
  logic [3:0]  a_sel;
  logic [15:0] b_data, b_wq;
  logic        b_valid, b_abort, b_ready, b_mux, b_tx, b_busy, b_done;
  logic [3:0]  b_sel;

  // The bench plays the external 16:1 mux for both instances.
  assign a_mux = a_wq[a_sel];
  assign b_mux = b_wq[b_sel];

  tx_word_sequencer #(.CLKS_PER_BIT(C)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .abort(a_abort), .word_q(a_wq), .sel(a_sel),
    .mux_in(a_mux), .tx_out(a_tx), .busy(a_busy), .done(a_done));

  tx_word_sequencer #(.CLKS_PER_BIT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .abort(b_abort), .word_q(b_wq), .sel(b_sel),
    .mux_in(b_mux), .tx_out(b_tx), .busy(b_busy), .done(b_done));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model for instance A.
  bit          m_active;
  int          m_off;
  logic [15:0] m_wq;
  logic [3:0]  m_sel_idle;
  bit          m_done;

  function automatic logic exp_tx(input logic [15:0] w, input int off);
    int b;
    b = off / C;
    if (b == 0) return 1'b0;
    if (b <= 16) return w[4'(b - 1)];
    return 1'b1;
  endfunction

  function automatic logic [3:0] exp_sel(input int off);
    int b;
    b = off / C;
    if (b == 0) return 4'd0;
    if (b <= 16) return 4'(b - 1);
    return 4'd15;
  endfunction

  task automatic model_reset();
    m_active   = 1'b0;
    m_off      = 0;
    m_wq       = 16'h0;
    m_sel_idle = 4'd0;
    m_done     = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [15:0] d, input logic a);
    if (m_active) begin
      if (a) begin
        m_active = 1'b0; m_sel_idle = 4'd0; m_done = 1'b0;
      end else if (m_off == FRAME - 1) begin
        m_active = 1'b0; m_sel_idle = 4'd15; m_done = 1'b1;
      end else begin
        m_off++; m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
      if (v) begin
        m_active = 1'b1; m_off = 0; m_wq = d;
      end
    end
  endtask

  task automatic model_check();
    check("m_tx",    32'(a_tx),    32'(m_active ? exp_tx(m_wq, m_off) : 1'b1));
    check("m_sel",   32'(a_sel),   32'(m_active ? exp_sel(m_off) : m_sel_idle));
    check("m_busy",  32'(a_busy),  32'(m_active));
    check("m_ready", 32'(a_ready), 32'(!m_active));
    check("m_done",  32'(a_done),  32'(m_done));
    check("m_wq",    32'(a_wq),    32'(m_wq));
  endtask

  // One clock of instance A: drive, edge, model update, check at negedge.
  task automatic tick(input logic v, input logic [15:0] d, input logic a);
    a_valid = v; a_data = d; a_abort = a;
    @(posedge clk);
    model_step(v, d, a);
    @(negedge clk);
    model_check();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < FRAME + 2 && m_active; i++) tick(1'b0, 16'($urandom), 1'b0);
    if (m_active) check("idle_timeout", 32'(1), 32'(0));
  endtask

  typedef struct {
    logic [15:0] word;
    logic [17:0] bits;  // {stop, data bit15..bit0, start}
  } vec_t;

  vec_t tbl[4];
  logic [17:0] bseq;

  initial begin
    tbl[0] = '{16'hA5C3, 18'b1_1010010111000011_0};
    tbl[1] = '{16'hFFFF, 18'b1_1111111111111111_0};
    tbl[2] = '{16'h0000, 18'b1_0000000000000000_0};
    tbl[3] = '{16'h8001, 18'b1_1000000000000001_0};

    rst_n = 1'b0;
    a_valid = 1'b0; a_data = 16'h0; a_abort = 1'b0;
    b_valid = 1'b0; b_data = 16'h0; b_abort = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_tx",   32'(a_tx),   32'(1));
    check("rst_busy", 32'(a_busy), 32'(0));
    check("rst_done", 32'(a_done), 32'(0));
    check("rst_sel",  32'(a_sel),  32'(0));
    check("rst_wq",   32'(a_wq),   32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    model_check();

    // Table-driven frames on CLKS_PER_BIT=4.
    for (int i = 0; i < 4; i++) begin
      wait_idle();
      tick(1'b1, tbl[i].word, 1'b0);
      for (int t = 0; t < FRAME; t++) begin
        if (t > 0) tick(1'b0, 16'($urandom), 1'b0);
        check("tbl_tx", 32'(a_tx), 32'(tbl[i].bits[5'(t / C)]));
        if ((t % C) == 0)
          check("tbl_sel", 32'(a_sel), 32'((t / C == 0) ? 0 : ((t / C - 1 > 15) ? 15 : t / C - 1)));
      end
      tick(1'b0, 16'h0, 1'b0);
      check("tbl_done",  32'(a_done),  32'(1));
      check("tbl_ready", 32'(a_ready), 32'(1));
    end

    // Back-to-back with in_valid held high.
    wait_idle();
    tick(1'b1, 16'hFFFF, 1'b0);
    repeat (FRAME) tick(1'b1, 16'hFFFF, 1'b0);
    check("b2b_done", 32'(a_done), 32'(1));
    check("b2b_gap",  32'(a_tx),   32'(1));
    tick(1'b1, 16'h0000, 1'b0);
    check("b2b_busy2", 32'(a_busy), 32'(1));
    check("b2b_start", 32'(a_tx),   32'(0));
    check("b2b_wq2",   32'(a_wq),   32'(16'h0000));
    repeat (FRAME) tick(1'b1, 16'h0000, 1'b0);
    check("b2b_done2", 32'(a_done), 32'(1));
    tick(1'b0, 16'h0, 1'b0);
    wait_idle();

    // Abort in DATA at sel=7, then immediate new word.
    tick(1'b1, 16'hB6E1, 1'b0);
    repeat (8 * C + 1) tick(1'b0, 16'($urandom), 1'b0);
    check("abt_sel7", 32'(a_sel), 32'(7));
    tick(1'b0, 16'h0, 1'b1);
    check("abt_busy",  32'(a_busy),  32'(0));
    check("abt_tx",    32'(a_tx),    32'(1));
    check("abt_sel",   32'(a_sel),   32'(0));
    check("abt_ready", 32'(a_ready), 32'(1));
    check("abt_done",  32'(a_done),  32'(0));
    tick(1'b1, 16'h2468, 1'b0);
    check("abt_new", 32'(a_wq), 32'(16'h2468));
    wait_idle();

    // Abort in IDLE is ignored; handshake proceeds.
    tick(1'b0, 16'h0, 1'b0);
    tick(1'b1, 16'h9ABC, 1'b1);
    check("idle_abt", 32'(a_busy), 32'(1));
    wait_idle();

    // Busy-time input toggling.
    tick(1'b1, 16'h5A3C, 1'b0);
    for (int t = 1; t < FRAME; t++) begin
      tick(1'($urandom), 16'($urandom), 1'b0);
      check("bsy_ready", 32'(a_ready), 32'(0));
      check("bsy_wq",    32'(a_wq),    32'(16'h5A3C));
    end
    tick(1'b0, 16'h0, 1'b0);
    check("bsy_done", 32'(a_done), 32'(1));

    // CLKS_PER_BIT=1 instance: 16'h0001 gives an 18-cycle frame.
    bseq = 18'b1_0000000000000001_0;
    b_valid = 1'b1; b_data = 16'h0001;
    tick(1'b0, 16'h0, 1'b0);
    b_valid = 1'b0; b_data = 16'hFFFF;
    for (int t = 0; t < 18; t++) begin
      check("c1_tx",   32'(b_tx),   32'(bseq[5'(t)]));
      check("c1_done", 32'(b_done), 32'(0));
      tick(1'b0, 16'h0, 1'b0);
    end
    check("c1_done_end", 32'(b_done),  32'(1));
    check("c1_ready",    32'(b_ready), 32'(1));

    // Async reset in the middle of STOP.
    wait_idle();
    tick(1'b1, 16'hC0DE, 1'b0);
    repeat (17 * C + 1) tick(1'b0, 16'h0, 1'b0);
    check("ar_busy_pre", 32'(a_busy), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    check("ar_tx",   32'(a_tx),   32'(1));
    check("ar_busy", 32'(a_busy), 32'(0));
    check("ar_done", 32'(a_done), 32'(0));
    check("ar_sel",  32'(a_sel),  32'(0));
    check("ar_wq",   32'(a_wq),   32'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("ar_ready", 32'(a_ready), 32'(1));
    repeat (C * 2) tick(1'b0, 16'h0, 1'b0);
    tick(1'b1, 16'h1357, 1'b0);
    repeat (FRAME) tick(1'b0, 16'h0, 1'b0);
    check("ar_frame_done", 32'(a_done), 32'(1));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++)
      tick(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 39) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_word_sequencer.md
# tx_word_sequencer

Controller that serializes one 16-bit word per frame through the transmit path's 16:1 single-bit mux. It accepts a word on a valid/ready handshake and latches it onto the mux data inputs. It then steps the mux select 0..15, framing the result with a start bit and a stop bit on the serial line `tx_out`. It sits between the transmit FSM's word source and the serial pin, driving `sel`/`word_q` into the mux and taking the mux output back on `mux_in`.

## Interface
- `CLKS_PER_BIT`, 4: clock cycles each serial bit is held; legal range 1..65535.
- `clk`  input  1  system clock, all state on rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `in_data`  input  16  word to transmit.
- `in_valid`  input  1  `in_data` valid.
- `in_ready`  output  1  high only in IDLE; transfer occurs when `in_valid && in_ready` at a rising edge.
- `abort`  input  1  synchronous frame abort.
- `word_q`  output  16  latched word; bit k wires to mux input k (A=bit0 … P=bit15).
- `sel`  output  4  mux select.
- `mux_in`  input  1  output of the 16:1 mux.
- `tx_out`  output  1  serial line, idle high.
- `busy`  output  1  high in START/DATA/STOP.
- `done`  output  1  one-cycle pulse on normal frame completion.

## Operation
- States:
  - IDLE, START, DATA, STOP, all registered.
  - Bit-period counter `bcnt` is sized to hold CLKS_PER_BIT-1.
  - Bit index is the `sel` register.
- IDLE:
  - `in_ready`=1, `tx_out`=1.
  - On handshake: `word_q`←`in_data`, `sel`←0, `bcnt`←0, go to START.
- START:
  - `tx_out`=0.
  - When `bcnt`==CLKS_PER_BIT-1: `bcnt`←0, go to DATA; otherwise `bcnt`++.
- DATA:
  - `tx_out`=`mux_in`, combinational from registered `sel`/`word_q` through the mux; LSB first.
  - At end of each bit period: if `sel`==15, go to STOP with `sel` held at 15; else `sel`++.
- STOP:
  - `tx_out`=1.
  - At end of period: go to IDLE, `done`=1 for exactly that transition cycle (registered, asserted the first IDLE cycle).
- `abort`:
  - Sampled high in START/DATA/STOP: next state IDLE, `tx_out`=1, `sel`←0, `bcnt`←0, no `done`.
  - Ignored in IDLE; a handshake in the same cycle proceeds.
- `in_valid` while busy is ignored; `in_data` changes while busy do not affect `word_q`.
- `word_q` changes only on handshake.

## Timing
- Reset (`rst_n`=0, takes effect immediately): state IDLE, `word_q`=0, `sel`=0, `bcnt`=0, `done`=0, `busy`=0, `tx_out`=1, `in_ready`=1 after release.
- Reset asserted mid-frame terminates the frame at once; no `done`.
- Handshake at edge n: START (`tx_out`=0) visible from cycle n+1.
- Frame occupies 18×CLKS_PER_BIT cycles from n+1.
- `done` is high in cycle n+1+18×CLKS_PER_BIT, which is also the first cycle `in_ready`=1 again.
- Back-to-back max rate: next handshake may occur at that same edge, giving one IDLE cycle between frames.
- `busy` = not IDLE, registered state decode, no added latency.
- CLKS_PER_BIT=1: each state/bit lasts exactly one cycle, and the `bcnt` wrap condition is always true.
- `sel` changes only at bit-period boundaries, so `tx_out` is stable for whole periods apart from mux propagation.

## Test plan
- **Basic frame**: CLKS_PER_BIT=4, send 16'hA5C3.
  - Required `tx_out`: 0×4 cycles, then bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 each 4 cycles, then 1×4 cycles.
  - `done` pulses at cycle n+73; `sel` walks 0..15.
- **Back-to-back**: `in_valid` held high with 16'hFFFF then 16'h0000.
  - Second handshake occurs on the `done` cycle.
  - Frames are separated by exactly one idle-high cycle.
  - Both frames serialize correctly.
- **Abort**: abort asserted in DATA at `sel`=7.
  - Next cycle: IDLE, `tx_out`=1, `sel`=0, `in_ready`=1, no `done`.
  - A new word is accepted immediately.
- **Async reset mid-STOP**: pull `rst_n` low.
  - All outputs take their reset values without a clock edge.
  - No `done`; normal frame after release.
- **CLKS_PER_BIT=1**: send 16'h0001.
  - Frame is 18 cycles: 0, 1, fifteen 0s, 1.
  - `done` at n+19.
- **Busy-time stimulus**: toggle `in_valid`/`in_data` throughout a frame.
  - `word_q` and `tx_out` sequence unchanged.
  - `in_ready`=0 throughout.
